// File: rtl/aurora_ctrl_sequencer.sv
// Turns the asynchronous VIO control word into synchronized, debounced controls
// and runs the GT-reset / Aurora-reset / wait-for-channel-up bring-up sequence.
module aurora_ctrl_sequencer #(
    parameter int STABLE_CYCLES  = 16,
    parameter int GT_RST_CYCLES  = 64,
    parameter int AUR_RST_CYCLES = 128,
    parameter int UP_TIMEOUT     = 1048576,
    parameter int CNT_W          = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] aurora_ctrl,
    input  logic       channel_up,
    output logic       gt_reset,
    output logic       aurora_reset,
    output logic       power_down,
    output logic [2:0] loopback,
    output logic       test_start,
    output logic       err_clr,
    output logic       seq_busy,
    output logic       timeout_err,
    output logic [7:0] ctrl_filt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GT_RST  = 2'd1,
        AUR_RST = 2'd2,
        WAIT_UP = 2'd3
    } state_t;

    localparam logic [7:0]       STB_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GT_LAST  = CNT_W'(GT_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] AUR_LAST = CNT_W'(AUR_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] UP_LAST  = CNT_W'(UP_TIMEOUT - 1);

    logic [7:0]       sync1_q, sync2_q;
    logic [7:0]       cand_q, cand_d;
    logic [7:0]       stab_cnt_q, stab_cnt_d;
    logic [7:0]       ctrl_filt_q, ctrl_filt_d;
    logic [2:0]       filt_hist_q;   // previous ctrl_filt bits {6,5,0}
    logic             rst_req_q, test_start_q, err_clr_q;
    logic             power_down_q;
    logic [2:0]       loopback_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;
    logic             timeout_q, timeout_d;

    // Debounce: the candidate must be seen unchanged for STABLE_CYCLES samples.
    always_comb begin
        cand_d      = cand_q;
        stab_cnt_d  = stab_cnt_q;
        ctrl_filt_d = ctrl_filt_q;
        if (sync2_q != cand_q) begin
            cand_d     = sync2_q;
            stab_cnt_d = 8'd0;
        end else if (stab_cnt_q == STB_LAST) begin
            if (cand_q != ctrl_filt_q) ctrl_filt_d = cand_q;
        end else begin
            stab_cnt_d = stab_cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        seq_cnt_d    = seq_cnt_q;
        timeout_d    = timeout_q;
        gt_reset     = 1'b0;
        aurora_reset = 1'b0;
        seq_busy     = 1'b1;
        case (state_q)
            IDLE: begin
                seq_busy  = 1'b0;
                seq_cnt_d = '0;
                if (rst_req_q) begin
                    timeout_d = 1'b0;
                    state_d   = GT_RST;
                end
            end
            GT_RST: begin
                gt_reset     = 1'b1;
                aurora_reset = 1'b1;
                if (seq_cnt_q == GT_LAST) begin
                    seq_cnt_d = '0;
                    state_d   = AUR_RST;
                end else begin
                    seq_cnt_d = seq_cnt_q + CNT_W'(1);
                end
            end
            AUR_RST: begin
                aurora_reset = 1'b1;
                if (seq_cnt_q == AUR_LAST) begin
                    seq_cnt_d = '0;
                    state_d   = WAIT_UP;
                end else begin
                    seq_cnt_d = seq_cnt_q + CNT_W'(1);
                end
            end
            WAIT_UP: begin
                // channel_up takes priority over a coincident timeout
                if (channel_up) begin
                    seq_cnt_d = '0;
                    state_d   = IDLE;
                end else if (seq_cnt_q == UP_LAST) begin
                    seq_cnt_d = '0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    seq_cnt_d = seq_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            cand_q       <= '0;
            stab_cnt_q   <= '0;
            ctrl_filt_q  <= '0;
            filt_hist_q  <= '0;
            rst_req_q    <= 1'b0;
            test_start_q <= 1'b0;
            err_clr_q    <= 1'b0;
            power_down_q <= 1'b0;
            loopback_q   <= '0;
            state_q      <= GT_RST;
            seq_cnt_q    <= '0;
            timeout_q    <= 1'b0;
        end else begin
            sync1_q      <= aurora_ctrl;
            sync2_q      <= sync1_q;
            cand_q       <= cand_d;
            stab_cnt_q   <= stab_cnt_d;
            ctrl_filt_q  <= ctrl_filt_d;
            filt_hist_q  <= {ctrl_filt_q[6], ctrl_filt_q[5], ctrl_filt_q[0]};
            rst_req_q    <= ctrl_filt_q[0] & ~filt_hist_q[0];
            test_start_q <= ctrl_filt_q[5] & ~filt_hist_q[1];
            err_clr_q    <= ctrl_filt_q[6] & ~filt_hist_q[2];
            power_down_q <= ctrl_filt_q[1];
            loopback_q   <= ctrl_filt_q[4:2];
            state_q      <= state_d;
            seq_cnt_q    <= seq_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign power_down  = power_down_q;
    assign loopback    = loopback_q;
    assign test_start  = test_start_q;
    assign err_clr     = err_clr_q;
    assign timeout_err = timeout_q;
    assign ctrl_filt   = ctrl_filt_q;

endmodule

// File: tb/tb_aurora_ctrl_sequencer.sv
// Directed bench for aurora_ctrl_sequencer: vector table for the filter path,
// hand-written sequences for the reset sequencer corner cases.
module tb_aurora_ctrl_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] aurora_ctrl;
    logic       channel_up;
    logic       gt_reset, aurora_reset, power_down, test_start, err_clr;
    logic       seq_busy, timeout_err;
    logic [2:0] loopback;
    logic [7:0] ctrl_filt;

    int n_checks = 0;
    int n_fail   = 0;
    int ts_cnt   = 0;
    int ec_cnt   = 0;

    aurora_ctrl_sequencer #(
        .STABLE_CYCLES (4),
        .GT_RST_CYCLES (8),
        .AUR_RST_CYCLES(16),
        .UP_TIMEOUT    (100),
        .CNT_W         (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .aurora_ctrl (aurora_ctrl),
        .channel_up  (channel_up),
        .gt_reset    (gt_reset),
        .aurora_reset(aurora_reset),
        .power_down  (power_down),
        .loopback    (loopback),
        .test_start  (test_start),
        .err_clr     (err_clr),
        .seq_busy    (seq_busy),
        .timeout_err (timeout_err),
        .ctrl_filt   (ctrl_filt)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse-cycle counters, sampled away from the active edge
    always @(negedge clk) begin
        if (test_start) ts_cnt++;
        if (err_clr) ec_cnt++;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called right after rst_n is released with channel_up=1.
    task automatic check_release_seq(input string tag);
        int gt_n, aur_n, busy_fall;
        gt_n = 0;
        aur_n = 0;
        busy_fall = -1;
        for (int i = 0; i <= 40; i++) begin
            if (gt_reset) gt_n++;
            if (aurora_reset) aur_n++;
            if (!seq_busy && busy_fall < 0) busy_fall = i;
            step();
        end
        check({tag, "_gt_len"}, 32'(gt_n), 32'd8);
        check({tag, "_aur_len"}, 32'(aur_n), 32'd24);
        check({tag, "_busy_fall"}, 32'(busy_fall), 32'd25);
        check({tag, "_busy_end"}, 32'(seq_busy), 32'd0);
        check({tag, "_timeout"}, 32'(timeout_err), 32'd0);
    endtask

    typedef struct {
        logic [7:0] ctrl;
        logic [7:0] exp_filt;
        logic [2:0] exp_lb;
        logic       exp_pd;
        int         exp_ts;
        int         exp_ec;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int ts0, ec0, gt_late, fall;

        vecs[0] = '{8'h02, 8'h02, 3'd0, 1'b1, 0, 0};
        vecs[1] = '{8'h0A, 8'h0A, 3'd2, 1'b1, 0, 0};
        vecs[2] = '{8'h14, 8'h14, 3'd5, 1'b0, 0, 0};
        vecs[3] = '{8'h80, 8'h80, 3'd0, 1'b0, 0, 0};
        vecs[4] = '{8'h20, 8'h20, 3'd0, 1'b0, 1, 0};
        vecs[5] = '{8'h60, 8'h60, 3'd0, 1'b0, 0, 1};
        vecs[6] = '{8'h00, 8'h00, 3'd0, 1'b0, 0, 0};
        vecs[7] = '{8'h7E, 8'h7E, 3'd7, 1'b1, 1, 1};
        vecs[8] = '{8'h1C, 8'h1C, 3'd7, 1'b0, 0, 0};
        vecs[9] = '{8'h00, 8'h00, 3'd0, 1'b0, 0, 0};

        rst_n = 1'b0;
        aurora_ctrl = 8'h00;
        channel_up = 1'b1;
        step(3);
        check("rst_gt", 32'(gt_reset), 32'd1);
        check("rst_aur", 32'(aurora_reset), 32'd1);
        check("rst_busy", 32'(seq_busy), 32'd1);
        check("rst_filt", 32'(ctrl_filt), 32'd0);
        check("rst_pulses", 32'({test_start, err_clr, power_down}), 32'd0);
        check("rst_lb", 32'(loopback), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);

        rst_n = 1'b1;
        check_release_seq("por");

        // filter latency and registered loopback
        ts0 = ts_cnt;
        ec0 = ec_cnt;
        aurora_ctrl = 8'h1C;
        step(6);
        check("lat_filt_early", 32'(ctrl_filt), 32'h00);
        step(1);
        check("lat_filt", 32'(ctrl_filt), 32'h1C);
        check("lat_lb_early", 32'(loopback), 32'd0);
        step(1);
        check("lat_lb", 32'(loopback), 32'd7);
        step(2);
        check("lat_no_ts", 32'(ts_cnt - ts0), 32'd0);
        check("lat_no_ec", 32'(ec_cnt - ec0), 32'd0);
        check("lat_idle", 32'(seq_busy), 32'd0);

        for (int v = 0; v < 10; v++) begin
            ts0 = ts_cnt;
            ec0 = ec_cnt;
            aurora_ctrl = vecs[v].ctrl;
            step(10);
            check($sformatf("vec%0d_filt", v), 32'(ctrl_filt), 32'(vecs[v].exp_filt));
            check($sformatf("vec%0d_lb", v), 32'(loopback), 32'(vecs[v].exp_lb));
            check($sformatf("vec%0d_pd", v), 32'(power_down), 32'(vecs[v].exp_pd));
            check($sformatf("vec%0d_ts", v), 32'(ts_cnt - ts0), 32'(vecs[v].exp_ts));
            check($sformatf("vec%0d_ec", v), 32'(ec_cnt - ec0), 32'(vecs[v].exp_ec));
            check($sformatf("vec%0d_idle", v), 32'(seq_busy), 32'd0);
        end

        // simultaneous rises on bits 0, 5, 6
        aurora_ctrl = 8'h61;
        step(8);
        check("sim_ts", 32'(test_start), 32'd1);
        check("sim_ec", 32'(err_clr), 32'd1);
        check("sim_busy_early", 32'(seq_busy), 32'd0);
        step(1);
        check("sim_busy", 32'(seq_busy), 32'd1);
        check("sim_ts_off", 32'(test_start), 32'd0);
        step(30);
        check("sim_done", 32'(seq_busy), 32'd0);
        aurora_ctrl = 8'h00;
        step(10);

        // 3-clock glitch on bit 5 is rejected
        ts0 = ts_cnt;
        aurora_ctrl = 8'h20;
        step(3);
        aurora_ctrl = 8'h00;
        step(10);
        check("glitch_filt", 32'(ctrl_filt), 32'h00);
        check("glitch_ts", 32'(ts_cnt - ts0), 32'd0);
        aurora_ctrl = 8'h20;
        step(7);
        check("hold_filt", 32'(ctrl_filt), 32'h20);
        check("hold_ts_early", 32'(test_start), 32'd0);
        step(1);
        check("hold_ts_on", 32'(test_start), 32'd1);
        step(1);
        check("hold_ts_off", 32'(test_start), 32'd0);
        step(5);
        check("hold_ts_count", 32'(ts_cnt - ts0), 32'd1);
        aurora_ctrl = 8'h00;
        step(10);

        // channel_up never arrives: timeout after 100 WAIT_UP clocks
        channel_up = 1'b0;
        aurora_ctrl = 8'h01;
        step(8);
        check("to_busy_early", 32'(seq_busy), 32'd0);
        step(1);
        check("to_busy", 32'(seq_busy), 32'd1);
        check("to_gt", 32'(gt_reset), 32'd1);
        step(123);
        check("to_pre_busy", 32'(seq_busy), 32'd1);
        check("to_pre_err", 32'(timeout_err), 32'd0);
        step(1);
        check("to_idle", 32'(seq_busy), 32'd0);
        check("to_err", 32'(timeout_err), 32'd1);
        aurora_ctrl = 8'h00;
        step(10);
        check("to_err_sticky", 32'(timeout_err), 32'd1);
        aurora_ctrl = 8'h01;
        channel_up = 1'b1;
        step(8);
        check("to_err_before_acc", 32'(timeout_err), 32'd1);
        step(1);
        check("to_err_cleared", 32'(timeout_err), 32'd0);
        check("to_reacc_busy", 32'(seq_busy), 32'd1);

        // second request during AUR_RST is ignored
        aurora_ctrl = 8'h00;
        step(8);
        aurora_ctrl = 8'h01;
        gt_late = 0;
        fall = -1;
        for (int t = 9; t <= 45; t++) begin
            step();
            if (gt_reset) gt_late++;
            if (!seq_busy && fall < 0) fall = t;
        end
        check("ign_no_gt", 32'(gt_late), 32'd0);
        check("ign_fall", 32'(fall), 32'd25);
        check("ign_idle", 32'(seq_busy), 32'd0);
        check("ign_filt", 32'(ctrl_filt), 32'h01);

        // channel_up on the timeout cycle wins
        aurora_ctrl = 8'h00;
        step(10);
        channel_up = 1'b0;
        aurora_ctrl = 8'h01;
        step(9);
        check("tie_busy", 32'(seq_busy), 32'd1);
        step(123);
        check("tie_pre_busy", 32'(seq_busy), 32'd1);
        channel_up = 1'b1;
        step(1);
        check("tie_idle", 32'(seq_busy), 32'd0);
        check("tie_no_err", 32'(timeout_err), 32'd0);

        // rst_n in the middle of WAIT_UP
        aurora_ctrl = 8'h00;
        step(10);
        channel_up = 1'b0;
        aurora_ctrl = 8'h1D;
        step(9);
        check("mid_busy", 32'(seq_busy), 32'd1);
        step(34);
        check("mid_wait_gt", 32'(gt_reset), 32'd0);
        check("mid_wait_aur", 32'(aurora_reset), 32'd0);
        check("mid_wait_busy", 32'(seq_busy), 32'd1);
        check("mid_wait_filt", 32'(ctrl_filt), 32'h1D);
        check("mid_wait_lb", 32'(loopback), 32'd7);
        rst_n = 1'b0;
        step(1);
        check("mid_rst_gt", 32'(gt_reset), 32'd1);
        check("mid_rst_aur", 32'(aurora_reset), 32'd1);
        check("mid_rst_busy", 32'(seq_busy), 32'd1);
        check("mid_rst_filt", 32'(ctrl_filt), 32'h00);
        check("mid_rst_lb", 32'(loopback), 32'd0);
        rst_n = 1'b1;
        channel_up = 1'b1;
        check_release_seq("mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
